mac_tcdm_responder: RTL and testbench



---
 rtl/mac_tcdm_responder_pkg.sv | 22 ++
 rtl/mac_tcdm_responder_if.sv | 24 ++
 rtl/mac_tcdm_responder_rr_arbiter.sv | 61 ++++++
 rtl/mac_tcdm_responder.sv | 152 +++++++++++++++
 tb/tb_mac_tcdm_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_tcdm_responder_pkg.sv
// Shared constants and small helpers for the MAC TCDM responder.
// Optional feature macro used by this slice: MAC_TCDM_RESP_STALL_EN.
package mac_tcdm_responder_pkg;

  localparam int MAC_TCDM_DW   = 32;
  localparam int MAC_TCDM_BE_W = 4;

  localparam logic [15:0] MAC_TCDM_LFSR_SEED = 16'hACE1;

  // Saturating +1 for the access counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

endpackage

// File: rtl/mac_tcdm_responder_if.sv
// TCDM request/response bundle: the requester drives the request fields and
// holds them until gnt; the responder answers with r_valid/r_data.
interface hwpe_stream_intf_tcdm;

  logic                                                req;
  logic                                                gnt;
  logic [31:0]                                         add;
  logic                                                wen;
  logic [mac_tcdm_responder_pkg::MAC_TCDM_BE_W-1:0]    be;
  logic [mac_tcdm_responder_pkg::MAC_TCDM_DW-1:0]      data;
  logic [mac_tcdm_responder_pkg::MAC_TCDM_DW-1:0]      r_data;
  logic                                                r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/mac_tcdm_responder_rr_arbiter.sv
// Round-robin arbiter: NP requests -> one-hot grant, granted index, and the
// rotating priority pointer. Grants are combinational; en_i gates all of them.
module mac_tcdm_rr_arbiter #(
  parameter int NP = 2,
  localparam int PW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [NP-1:0] req_i,
  output logic [NP-1:0] gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] cand_s [NP];
  logic [NP-1:0] gnt_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Candidate port for each priority slot: ptr, ptr+1, ... modulo NP
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      cand_s[i] = PW'((int'(ptr_r) + i) % NP);
    end
  end

  // First requesting candidate in priority order wins
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (en_i && !found_s && req_i[cand_s[i]]) begin
        found_s           = 1'b1;
        idx_s             = cand_s[i];
        gnt_s[cand_s[i]]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves to the port after the winner; it stays put when idle
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (idx_s == PW'(NP - 1)) ? '0 : (idx_s + PW'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt_o   = gnt_s;
  assign idx_o   = idx_s;
  assign valid_o = found_s;

endmodule

// File: rtl/mac_tcdm_responder.sv
// Single-bank word memory shared by NP TCDM ports with round-robin grant and a
// fixed one-cycle registered response. Optional back-pressure generator is
// enabled by defining MAC_TCDM_RESP_STALL_EN.
module mac_tcdm_responder
  import mac_tcdm_responder_pkg::*;
#(
  parameter int NP    = 2,
  parameter int DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.slave  tcdm [NP-1:0],
  output logic                 err_o,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  logic [NP-1:0]              req_s;
  logic [31:0]                add_s  [NP];
  logic [NP-1:0]              wen_s;
  logic [MAC_TCDM_BE_W-1:0]   be_s   [NP];
  logic [MAC_TCDM_DW-1:0]     data_s [NP];

  logic [NP-1:0]              gnt_s;
  logic [PW-1:0]              idx_s;
  logic                       valid_s;
  logic                       stall_s;
  logic                       grant_en_s;

  logic [31:0]                sel_add_s;
  logic                       sel_wen_s;
  logic [MAC_TCDM_BE_W-1:0]   sel_be_s;
  logic [MAC_TCDM_DW-1:0]     sel_data_s;
  logic [AW-1:0]              widx_s;
  logic                       oor_s;
  logic                       unused_add_s;

  logic [MAC_TCDM_DW-1:0]     mem_r    [DEPTH];
  logic [NP-1:0]              rvalid_r;
  logic [MAC_TCDM_DW-1:0]     rdata_r  [NP];
  logic [31:0]                rd_cnt_r;
  logic [31:0]                wr_cnt_r;
  logic                       err_r;

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign req_s[p]          = tcdm[p].req;
    assign add_s[p]          = tcdm[p].add;
    assign wen_s[p]          = tcdm[p].wen;
    assign be_s[p]           = tcdm[p].be;
    assign data_s[p]         = tcdm[p].data;
    assign tcdm[p].gnt       = gnt_s[p];
    assign tcdm[p].r_valid   = rvalid_r[p];
    assign tcdm[p].r_data    = rdata_r[p];
  end

`ifdef MAC_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_r;

  // Free-running pseudo-random stall source; low bits 00 block every grant
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lfsr_r <= MAC_TCDM_LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // No request is considered while reset/clear is applied or on a stall cycle
  assign grant_en_s = !rst_i && !clear_i && !stall_s;

  mac_tcdm_rr_arbiter #(
    .NP (NP)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .en_i    (grant_en_s),
    .req_i   (req_s),
    .gnt_o   (gnt_s),
    .idx_o   (idx_s),
    .valid_o (valid_s)
  );

  assign sel_add_s  = add_s[idx_s];
  assign sel_wen_s  = wen_s[idx_s];
  assign sel_be_s   = be_s[idx_s];
  assign sel_data_s = data_s[idx_s];

  // Byte offset is ignored; any upper address bit wraps the index and flags error
  assign widx_s       = sel_add_s[AW+1:2];
  assign oor_s        = |sel_add_s[31:AW+2];
  assign unused_add_s = ^sel_add_s[1:0];

  // Byte-masked store into the word array; contents survive reset and clear
  always_ff @(posedge clk_i) begin
    if (valid_s && !sel_wen_s) begin
      for (int b = 0; b < MAC_TCDM_BE_W; b++) begin
        if (sel_be_s[b]) begin
          mem_r[widx_s][8*b +: 8] <= sel_data_s[8*b +: 8];
        end
      end
    end
  end

  // One-cycle response to the granted port plus saturating access counters
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rvalid_r <= '0;
      for (int p = 0; p < NP; p++) begin
        rdata_r[p] <= 32'd0;
      end
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else begin
      rvalid_r <= gnt_s;
      if (valid_s) begin
        if (sel_wen_s) begin
          rdata_r[idx_s] <= mem_r[widx_s];
          rd_cnt_r       <= sat_inc32(rd_cnt_r);
        end else begin
          rdata_r[idx_s] <= 32'd0;
          wr_cnt_r       <= sat_inc32(wr_cnt_r);
        end
      end
    end
  end

  // Sticky out-of-range flag; only a hard reset clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (valid_s && oor_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o    = err_r;
  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;

endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Directed bench for mac_tcdm_responder (NP=2, DEPTH=1024).
module tb_mac_tcdm_responder;

  logic        clk;
  logic        rst_i;
  logic        clear_i;
  logic        err_o;
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;

  logic        req_v  [2];
  logic        wen_v  [2];
  logic [31:0] add_v  [2];
  logic [3:0]  be_v   [2];
  logic [31:0] data_v [2];
  logic [1:0]  gnt_v;
  logic [1:0]  rvalid_v;
  logic [31:0] rdata_a [2];

  int total = 0;
  int bad   = 0;

  hwpe_stream_intf_tcdm tcdm_if [1:0] ();

  assign tcdm_if[0].req  = req_v[0];
  assign tcdm_if[0].wen  = wen_v[0];
  assign tcdm_if[0].add  = add_v[0];
  assign tcdm_if[0].be   = be_v[0];
  assign tcdm_if[0].data = data_v[0];
  assign tcdm_if[1].req  = req_v[1];
  assign tcdm_if[1].wen  = wen_v[1];
  assign tcdm_if[1].add  = add_v[1];
  assign tcdm_if[1].be   = be_v[1];
  assign tcdm_if[1].data = data_v[1];
  assign gnt_v      = {tcdm_if[1].gnt, tcdm_if[0].gnt};
  assign rvalid_v   = {tcdm_if[1].r_valid, tcdm_if[0].r_valid};
  assign rdata_a[0] = tcdm_if[0].r_data;
  assign rdata_a[1] = tcdm_if[1].r_data;

  mac_tcdm_responder #(
    .NP    (2),
    .DEPTH (1024)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .tcdm     (tcdm_if),
    .err_o    (err_o),
    .rd_cnt_o (rd_cnt_o),
    .wr_cnt_o (wr_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wen, input logic [31:0] add,
                         input logic [3:0] be, input logic [31:0] data);
    req_v[p]  = 1'b1;
    wen_v[p]  = wen;
    add_v[p]  = add;
    be_v[p]   = be;
    data_v[p] = data;
  endtask

  task automatic drop_req(input int p);
    req_v[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_req(0, 1'b1, 32'h0, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h4, 4'hF, 32'h0);
    tick();
    total++; if (gnt_v !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt_v); end
    total++; if (rvalid_v !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", rvalid_v); end
    total++; if (rdata_a[0] !== 32'h0 || rdata_a[1] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata_a[0], rdata_a[1]); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", rd_cnt_o, wr_cnt_o); end
    drop_req(0);
    drop_req(1);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt_v); end
    tick();
    set_req(0, 1'b1, 32'h10, 4'hF, 32'h0);
    total++; if (rvalid_v !== 2'b01) begin bad++; $display("FAIL wr_rvalid got=%b exp=01", rvalid_v); end
    total++; if (rdata_a[0] !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rdata_a[0]); end
    total++; if (wr_cnt_o !== 32'd1) begin bad++; $display("FAIL wr_cnt got=%0d exp=1", wr_cnt_o); end
    #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b exp=01", gnt_v); end
    tick();
    drop_req(0);
    total++; if (rvalid_v !== 2'b01) begin bad++; $display("FAIL rd_rvalid got=%b exp=01", rvalid_v); end
    total++; if (rdata_a[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata_a[0]); end
    total++; if (rd_cnt_o !== 32'd1) begin bad++; $display("FAIL rd_cnt got=%0d exp=1", rd_cnt_o); end
    tick();
    total++; if (rvalid_v !== 2'b00) begin bad++; $display("FAIL idle_rvalid got=%b exp=00", rvalid_v); end
    total++; if (rdata_a[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_rdata got=%h exp=deadbeef", rdata_a[0]); end
  endtask

  task automatic test_byte_enable();
    set_req(1, 1'b0, 32'h20, 4'hF, 32'h11223344);
    #1;
    total++; if (gnt_v !== 2'b10) begin bad++; $display("FAIL be_gnt got=%b exp=10", gnt_v); end
    tick();
    set_req(1, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD);
    tick();
    set_req(1, 1'b1, 32'h20, 4'hF, 32'h0);
    tick();
    set_req(1, 1'b0, 32'h20, 4'b0000, 32'hFFFFFFFF);
    total++; if (rvalid_v !== 2'b10) begin bad++; $display("FAIL be_rvalid got=%b exp=10", rvalid_v); end
    total++; if (rdata_a[1] !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge got=%h exp=11bb33dd", rdata_a[1]); end
    tick();
    total++; if (rdata_a[1] !== 32'h0) begin bad++; $display("FAIL be0_rdata got=%h exp=0", rdata_a[1]); end
    set_req(1, 1'b1, 32'h20, 4'hF, 32'h0);
    tick();
    drop_req(1);
    total++; if (rdata_a[1] !== 32'h11BB33DD) begin bad++; $display("FAIL be0_nowrite got=%h exp=11bb33dd", rdata_a[1]); end
    total++; if (wr_cnt_o !== 32'd4) begin bad++; $display("FAIL be_wr_cnt got=%0d exp=4", wr_cnt_o); end
    total++; if (rd_cnt_o !== 32'd3) begin bad++; $display("FAIL be_rd_cnt got=%0d exp=3", rd_cnt_o); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_req(0, 1'b1, 32'h10, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h20, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_g = ((i % 2) == 0) ? 2'b01 : 2'b10;
      #1;
      total++; if (gnt_v !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt_v, exp_g); end
      tick();
      total++; if (rvalid_v !== exp_g) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, rvalid_v, exp_g); end
      if ((i % 2) == 0) begin
        total++; if (rdata_a[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rr_rdata0[%0d] got=%h exp=deadbeef", i, rdata_a[0]); end
      end else begin
        total++; if (rdata_a[1] !== 32'h11BB33DD) begin bad++; $display("FAIL rr_rdata1[%0d] got=%h exp=11bb33dd", i, rdata_a[1]); end
      end
    end
    drop_req(0);
    drop_req(1);
    total++; if (rd_cnt_o !== 32'd4 || wr_cnt_o !== 32'd0) begin bad++; $display("FAIL rr_cnt got=%0d/%0d exp=4/0", rd_cnt_o, wr_cnt_o); end
    tick();
  endtask

  task automatic test_out_of_range();
    set_req(0, 1'b0, 32'h4, 4'hF, 32'h0BADF00D);
    tick();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL oor_pre_err got=%b exp=0", err_o); end
    set_req(0, 1'b1, 32'h0000_1004, 4'hF, 32'h0);
    #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL oor_gnt got=%b exp=01", gnt_v); end
    tick();
    drop_req(0);
    total++; if (rdata_a[0] !== 32'h0BADF00D) begin bad++; $display("FAIL oor_wrap got=%h exp=0badf00d", rdata_a[0]); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", err_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL oor_err_clear got=%b exp=1", err_o); end
    total++; if (rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0) begin bad++; $display("FAIL oor_cnt_clear got=%0d/%0d exp=0/0", rd_cnt_o, wr_cnt_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL oor_err_rst got=%b exp=0", err_o); end
  endtask

  task automatic test_clear_midop();
    set_req(0, 1'b1, 32'h10, 4'hF, 32'h0);
    tick();
    drop_req(0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    total++; if (rvalid_v !== 2'b00) begin bad++; $display("FAIL clr_rvalid got=%b exp=00", rvalid_v); end
    total++; if (rd_cnt_o !== 32'd0) begin bad++; $display("FAIL clr_rd_cnt got=%0d exp=0", rd_cnt_o); end
    set_req(0, 1'b1, 32'h10, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h20, 4'hF, 32'h0);
    #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL clr_ptr got=%b exp=01", gnt_v); end
    tick();
    drop_req(0);
    total++; if (rdata_a[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL clr_mem0 got=%h exp=deadbeef", rdata_a[0]); end
    #1;
    total++; if (gnt_v !== 2'b10) begin bad++; $display("FAIL clr_gnt1 got=%b exp=10", gnt_v); end
    tick();
    drop_req(1);
    total++; if (rvalid_v !== 2'b10) begin bad++; $display("FAIL clr_rvalid1 got=%b exp=10", rvalid_v); end
    total++; if (rdata_a[1] !== 32'h11BB33DD) begin bad++; $display("FAIL clr_mem1 got=%h exp=11bb33dd", rdata_a[1]); end
    tick();
  endtask

`ifdef MAC_TCDM_RESP_STALL_EN
  task automatic test_stall();
    logic [15:0] lfsr;
    logic        fb;
    logic        exp_g;
    int          granted;
    granted = 0;
    rst_i   = 1'b1;
    tick();
    rst_i   = 1'b0;
    lfsr    = 16'hACE1;
    set_req(0, 1'b1, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 64; i++) begin
      exp_g = (lfsr[1:0] != 2'b00);
      #1;
      total++; if (gnt_v[0] !== exp_g) begin bad++; $display("FAIL stall_gnt[%0d] got=%b exp=%b", i, gnt_v[0], exp_g); end
      if (exp_g) granted++;
      tick();
      fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
      lfsr = {fb, lfsr[15:1]};
    end
    drop_req(0);
    total++; if (rd_cnt_o !== 32'(granted)) begin bad++; $display("FAIL stall_rd_cnt got=%0d exp=%0d", rd_cnt_o, granted); end
  endtask
`endif

  initial begin
    rst_i   = 1'b1;
    clear_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_v[p]  = 1'b0;
      wen_v[p]  = 1'b1;
      add_v[p]  = 32'h0;
      be_v[p]   = 4'h0;
      data_v[p] = 32'h0;
    end
    test_reset();
`ifdef MAC_TCDM_RESP_STALL_EN
    test_stall();
`else
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_out_of_range();
    test_clear_midop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
